// File: rtl/spart_rx.sv
// spart_rx: 16x-oversampled UART receiver (8N1, LSB first) with rda/overrun/frame_err status.
// Optional stop-bit checking is compiled in with `define SPART_RX_FRAME_ERR_EN.
module spart_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_enable,
  input  logic       rxd,
  input  logic       clr_rda,
  output logic [7:0] rx_data,
  output logic       rda,
  output logic       overrun,
  output logic       frame_err,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic       rxd_m;
  logic       rxd_s;
  logic [1:0] state;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       byte_done;

  assign state_dbg = state;

  // Synchronizer flops reset to the idle-line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  assign byte_done = (state == STOP) && sample_enable && (tick_cnt == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state    <= START;
            tick_cnt <= 4'd0;
          end
        end
        START: begin
          if (sample_enable) begin
            if (tick_cnt == 4'd7) begin
              if (!rxd_s) begin
                state    <= DATA;
                tick_cnt <= 4'd0;
                bit_cnt  <= 3'd0;
              end else begin
                state <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (sample_enable) begin
            // The counter wraps 15 -> 0 by itself, giving one sample per bit period.
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd15) begin
              shreg   <= {rxd_s, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= STOP;
            end
          end
        end
        STOP: begin
          if (sample_enable) begin
            tick_cnt <= tick_cnt + 4'd1;
            // Leaving at mid stop bit lets an immediately following start bit be seen.
            if (tick_cnt == 4'd15) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Consumer handshake: rda rises on byte completion and holds until clr_rda;
  // a completion in the same cycle as clr_rda wins and does not count as overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data <= 8'h00;
      rda     <= 1'b0;
      overrun <= 1'b0;
    end else if (byte_done) begin
      rx_data <= shreg;
      rda     <= 1'b1;
      overrun <= (overrun | rda) & ~clr_rda;
    end else if (clr_rda) begin
      rda     <= 1'b0;
      overrun <= 1'b0;
    end
  end

`ifdef SPART_RX_FRAME_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else if (byte_done) begin
      frame_err <= ~rxd_s;
    end
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule
